// File: rtl/decode_pkg.sv
// decode_pkg: default sizing for the decode/operand-fetch stage.
// DATA_W  register and operand width
// NREG    architectural register count
// CNT_W   pending-write counter width (max outstanding writes = 2^CNT_W-1)
package decode_pkg;

  localparam int DATA_W  = 16;
  localparam int NREG    = 8;
  localparam int CNT_W   = 2;
  localparam int REG_W   = $clog2(NREG);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

endpackage : decode_pkg

// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch-side, execute-side and write-back signals of the
// decode stage. The slave modport is the decode stage itself; the master
// modport is its environment (fetch, execute, write-back).
interface decode_pipe_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);

  // fetch side
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [15:0]       in_pc;
  logic [REG_W-1:0]  in_rs_sel;
  logic [REG_W-1:0]  in_rt_sel;
  logic              in_rs_use;
  logic              in_rt_use;
  logic [REG_W-1:0]  in_rd_sel;
  logic              in_rd_wen;

  // execute side
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_instr;
  logic [15:0]       out_pc;
  logic [DATA_W-1:0] out_rs_data;
  logic [DATA_W-1:0] out_rt_data;
  logic [REG_W-1:0]  out_rd_sel;
  logic              out_rd_wen;
  logic              flush;

  // write-back and status
  logic              wb_en;
  logic [REG_W-1:0]  wb_sel;
  logic [DATA_W-1:0] wb_data;
  logic              busy;
  logic              err;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs_sel, in_rt_sel, in_rs_use, in_rt_use,
           in_rd_sel, in_rd_wen, out_ready, flush, wb_en, wb_sel, wb_data,
    output in_ready, out_valid, out_instr, out_pc, out_rs_data, out_rt_data,
           out_rd_sel, out_rd_wen, busy, err
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rs_sel, in_rt_sel, in_rs_use, in_rt_use,
           in_rd_sel, in_rd_wen, out_ready, flush, wb_en, wb_sel, wb_data,
    input  in_ready, out_valid, out_instr, out_pc, out_rs_data, out_rt_data,
           out_rd_sel, out_rd_wen, busy, err
  );

endinterface : decode_pipe_if

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: one pending-write counter per register. Counters go up
// when a writer is accepted, down on write-back and when a writer is killed
// in the output slot. Reports RAW hazards for two sources, destination
// saturation, busy and a sticky error for write-back with nothing pending.
// Optional feature macro: DECODE_WB_BYPASS_EN (a counter at 1 being written
// back this cycle is not a hazard).
module decode_scoreboard #(
  parameter int NREG  = decode_pkg::NREG,
  parameter int CNT_W = decode_pkg::CNT_W,
  parameter int REG_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic [REG_W-1:0] inc_sel,
  input  logic             fl_en,
  input  logic [REG_W-1:0] fl_sel,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_sel,
  input  logic [REG_W-1:0] rs_sel,
  input  logic             rs_use,
  input  logic [REG_W-1:0] rt_sel,
  input  logic             rt_use,
  input  logic [REG_W-1:0] rd_sel,
  input  logic             rd_wen,
  output logic             hazard,
  output logic             sat,
  output logic             busy,
  output logic             err
);
  import decode_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [CNT_W+1:0] sum_s [NREG];
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             haz_rs_s, haz_rt_s;

  // Next counters: net change is +accept -writeback -flush, never below zero
  always_comb begin
    err_d  = err_q;
    busy_d = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      sum_s[i] = {2'b00, cnt_q[i]};
      if (inc_en && (inc_sel == REG_W'(i))) sum_s[i] = sum_s[i] + (CNT_W+2)'(1);
      else                                  sum_s[i] = sum_s[i];
      if (wb_en && (wb_sel == REG_W'(i))) begin
        if (cnt_q[i] != CNT_ZERO) sum_s[i] = sum_s[i] - (CNT_W+2)'(1);
        else                      err_d    = 1'b1;
      end else begin
        sum_s[i] = sum_s[i];
      end
      if (fl_en && (fl_sel == REG_W'(i))) sum_s[i] = sum_s[i] - (CNT_W+2)'(1);
      else                                sum_s[i] = sum_s[i];
      if (sum_s[i][CNT_W+1]) cnt_d[i] = CNT_ZERO;
      else                   cnt_d[i] = sum_s[i][CNT_W-1:0];
      busy_d = busy_d | (cnt_d[i] != CNT_ZERO);
    end
  end

  // Hazard and saturation lookup against the current counters
  always_comb begin
    haz_rs_s = rs_use && (cnt_q[rs_sel] != CNT_ZERO);
    haz_rt_s = rt_use && (cnt_q[rt_sel] != CNT_ZERO);
`ifdef DECODE_WB_BYPASS_EN
    if ((cnt_q[rs_sel] == CNT_ONE) && wb_en && (wb_sel == rs_sel)) haz_rs_s = 1'b0;
    else                                                           haz_rs_s = haz_rs_s;
    if ((cnt_q[rt_sel] == CNT_ONE) && wb_en && (wb_sel == rt_sel)) haz_rt_s = 1'b0;
    else                                                           haz_rt_s = haz_rt_s;
`endif
    hazard = haz_rs_s || haz_rt_s;
    sat    = rd_wen && (cnt_q[rd_sel] == CNT_FULL);
  end

  // Counter, busy and sticky error state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= CNT_ZERO;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign err  = err_q;

endmodule : decode_scoreboard

// File: rtl/decode_pipe.sv
// decode_pipe: pipelined decode/operand-fetch stage. Holds the register file
// and a single valid/ready output slot; stalls on RAW hazards and counter
// saturation reported by decode_scoreboard.
// Optional feature macro: DECODE_WB_BYPASS_EN (same-cycle write-back is
// forwarded into operand capture and clears a last-pending hazard).
module decode_pipe #(
  parameter int DATA_W = decode_pkg::DATA_W,
  parameter int NREG   = decode_pkg::NREG,
  parameter int CNT_W  = decode_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  decode_pipe_if.slave  bus
);
  import decode_pkg::*;

  localparam int REG_W = $clog2(NREG);

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_instr_q, out_instr_d;
  logic [15:0]       out_pc_q, out_pc_d;
  logic [DATA_W-1:0] out_rs_data_q, out_rs_data_d;
  logic [DATA_W-1:0] out_rt_data_q, out_rt_data_d;
  logic [REG_W-1:0]  out_rd_sel_q, out_rd_sel_d;
  logic              out_rd_wen_q, out_rd_wen_d;

  logic              hazard_s, sat_s, in_ready_s, accept_s, fl_en_s;
  logic [DATA_W-1:0] rs_rd_s, rt_rd_s;

  decode_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .REG_W(REG_W)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (accept_s && bus.in_rd_wen),
    .inc_sel (bus.in_rd_sel),
    .fl_en   (fl_en_s),
    .fl_sel  (out_rd_sel_q),
    .wb_en   (bus.wb_en),
    .wb_sel  (bus.wb_sel),
    .rs_sel  (bus.in_rs_sel),
    .rs_use  (bus.in_rs_use),
    .rt_sel  (bus.in_rt_sel),
    .rt_use  (bus.in_rt_use),
    .rd_sel  (bus.in_rd_sel),
    .rd_wen  (bus.in_rd_wen),
    .hazard  (hazard_s),
    .sat     (sat_s),
    .busy    (bus.busy),
    .err     (bus.err)
  );

  // Handshake: ready depends on state and stall inputs only, never on in_valid
  always_comb begin
    in_ready_s = !bus.flush && !hazard_s && !sat_s && (!out_valid_q || bus.out_ready);
    accept_s   = bus.in_valid && in_ready_s;
    fl_en_s    = bus.flush && out_valid_q && out_rd_wen_q;
  end

  // Operand read, optionally forwarding the write-back happening this cycle
  always_comb begin
    rs_rd_s = rf_q[bus.in_rs_sel];
    rt_rd_s = rf_q[bus.in_rt_sel];
`ifdef DECODE_WB_BYPASS_EN
    if (bus.wb_en && (bus.wb_sel == bus.in_rs_sel)) rs_rd_s = bus.wb_data;
    else                                            rs_rd_s = rs_rd_s;
    if (bus.wb_en && (bus.wb_sel == bus.in_rt_sel)) rt_rd_s = bus.wb_data;
    else                                            rt_rd_s = rt_rd_s;
`endif
  end

  // Register file write port
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (bus.wb_en && (bus.wb_sel == REG_W'(i))) rf_d[i] = bus.wb_data;
      else                                        rf_d[i] = rf_q[i];
    end
  end

  // Output slot: flush kills it, accept reloads it, consume empties it
  always_comb begin
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    out_rs_data_d = out_rs_data_q;
    out_rt_data_d = out_rt_data_q;
    out_rd_sel_d  = out_rd_sel_q;
    out_rd_wen_d  = out_rd_wen_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d   = 1'b1;
      out_instr_d   = bus.in_instr;
      out_pc_d      = bus.in_pc;
      out_rs_data_d = rs_rd_s;
      out_rt_data_d = rt_rd_s;
      out_rd_sel_d  = bus.in_rd_sel;
      out_rd_wen_d  = bus.in_rd_wen;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Register file and output slot state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= {DATA_W{1'b0}};
      out_valid_q   <= 1'b0;
      out_instr_q   <= 16'h0000;
      out_pc_q      <= 16'h0000;
      out_rs_data_q <= {DATA_W{1'b0}};
      out_rt_data_q <= {DATA_W{1'b0}};
      out_rd_sel_q  <= {REG_W{1'b0}};
      out_rd_wen_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      out_rs_data_q <= out_rs_data_d;
      out_rt_data_q <= out_rt_data_d;
      out_rd_sel_q  <= out_rd_sel_d;
      out_rd_wen_q  <= out_rd_wen_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_rs_data = out_rs_data_q;
  assign bus.out_rt_data = out_rt_data_q;
  assign bus.out_rd_sel  = out_rd_sel_q;
  assign bus.out_rd_wen  = out_rd_wen_q;

endmodule : decode_pipe

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed scenarios followed by random traffic. A reference
// model (pending-write counts, register values, list of issued writes) predicts
// in_ready/busy/err each cycle and queues the expected output slot contents;
// a separate monitor compares the slot against the queue.
module tb_decode_pipe;
  import decode_pkg::*;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [15:0]       instr;
    logic [15:0]       pc;
    logic [DATA_W-1:0] rs_d;
    logic [DATA_W-1:0] rt_d;
    logic [REG_W-1:0]  rd;
    logic              wen;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_pipe_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  decode_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  exp_t              expq[$];
  int                cnt[NREG];
  logic [DATA_W-1:0] rf[NREG];
  int                issued[$];
  bit                slot_full, slot_wen, err_m;
  int                slot_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < NREG; i++) if (cnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of stimulus: drive at negedge, check prediction, advance model
  task automatic step(input bit v, input int rs, input int rt, input int rd,
                      input bit rsu, input bit rtu, input bit rdw,
                      input bit ordy, input bit fl, input bit we, input int ws,
                      input logic [DATA_W-1:0] wd);
    bit hz_rs, hz_rt, sat, rdy, acc;
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_instr  = 16'($urandom);
    bus.in_pc     = 16'($urandom);
    bus.in_rs_sel = REG_W'(rs);
    bus.in_rt_sel = REG_W'(rt);
    bus.in_rd_sel = REG_W'(rd);
    bus.in_rs_use = rsu;
    bus.in_rt_use = rtu;
    bus.in_rd_wen = rdw;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.wb_en     = we;
    bus.wb_sel    = REG_W'(ws);
    bus.wb_data   = wd;
    #1;
    hz_rs = rsu && (cnt[rs] != 0) && !(BYP && cnt[rs] == 1 && we && ws == rs);
    hz_rt = rtu && (cnt[rt] != 0) && !(BYP && cnt[rt] == 1 && we && ws == rt);
    sat   = rdw && (cnt[rd] == CNT_MAX);
    rdy   = !fl && !hz_rs && !hz_rt && !sat && (!slot_full || ordy);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(slot_full));
    chk("busy", 32'(bus.busy), 32'(any_pending()));
    chk("err", 32'(bus.err), 32'(err_m));
    acc = v && rdy;
    if (acc) begin
      e.instr = bus.in_instr;
      e.pc    = bus.in_pc;
      e.rs_d  = (BYP && we && ws == rs) ? wd : rf[rs];
      e.rt_d  = (BYP && we && ws == rt) ? wd : rf[rt];
      e.rd    = REG_W'(rd);
      e.wen   = rdw;
      expq.push_back(e);
    end
    // write-back: retire one pending write, or flag an error when none
    if (we) begin
      if (cnt[ws] != 0) cnt[ws]--;
      else err_m = 1'b1;
      rf[ws] = wd;
      for (int k = 0; k < issued.size(); k++)
        if (issued[k] == ws) begin issued.delete(k); break; end
    end
    // the slot either dies (flush) or leaves for execute (consume)
    if (fl && slot_full && slot_wen) cnt[slot_rd]--;
    else if (!fl && slot_full && ordy && slot_wen) issued.push_back(slot_rd);
    if (acc && rdw) cnt[rd]++;
    if (fl)            slot_full = 1'b0;
    else if (acc)      begin slot_full = 1'b1; slot_wen = rdw; slot_rd = rd; end
    else if (ordy)     slot_full = 1'b0;
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 0, 0, 0, 0, 0, ordy, 0, 0, 0, '0);
  endtask

  task automatic wb(input int ws, input logic [DATA_W-1:0] wd);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, ws, wd);
  endtask

  task automatic wr(input int rd, input bit ordy);
    step(1, 0, 0, rd, 0, 0, 1, ordy, 0, 0, 0, '0);
  endtask

  // Monitor: compare the presented slot with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b1 && bus.out_valid === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL slot_unexpected: actual out_valid=1 required no pending output");
        end else begin
          e = expq[0];
          chk("out_instr", 32'(bus.out_instr), 32'(e.instr));
          chk("out_pc", 32'(bus.out_pc), 32'(e.pc));
          chk("out_rs_data", 32'(bus.out_rs_data), 32'(e.rs_d));
          chk("out_rt_data", 32'(bus.out_rt_data), 32'(e.rt_d));
          chk("out_rd_sel", 32'(bus.out_rd_sel), 32'(e.rd));
          chk("out_rd_wen", 32'(bus.out_rd_wen), 32'(e.wen));
          if (bus.flush || bus.out_ready) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    int rw;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = 16'h0000; bus.in_pc = 16'h0000;
    bus.in_rs_sel = '0; bus.in_rt_sel = '0; bus.in_rd_sel = '0;
    bus.in_rs_use = 1'b0; bus.in_rt_use = 1'b0; bus.in_rd_wen = 1'b0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_sel = '0; bus.wb_data = '0;
    for (int i = 0; i < NREG; i++) begin cnt[i] = 0; rf[i] = '0; end
    slot_full = 1'b0; slot_wen = 1'b0; slot_rd = 0; err_m = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", 32'(bus.out_instr), 32'd0);
    chk("rst_out_rs_data", 32'(bus.out_rs_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b1;

    // r3 = 0xBEEF through a proper write, then read it back
    wr(3, 1); idle(1); wb(3, 16'hBEEF);
    step(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
    idle(1); idle(1);

    // RAW on r2 resolved by write-back of 0x1234
    wr(2, 1);
    step(1, 2, 0, 6, 1, 0, 0, 1, 0, 0, 0, '0);
    step(1, 2, 0, 6, 1, 0, 0, 1, 0, 1, 2, 16'h1234);
    step(1, 2, 0, 6, 1, 0, 0, 1, 0, 0, 0, '0);
    idle(1);

    // saturation on r5, released by one write-back
    wr(5, 1); wr(5, 1); wr(5, 1);
    wr(5, 1);
    step(1, 0, 0, 5, 0, 0, 1, 1, 0, 1, 5, 16'h0505);
    wr(5, 1); idle(1);
    wb(5, 16'h1111); wb(5, 16'h2222); wb(5, 16'h3333);
    idle(1);

    // flush a held writer of r1
    wr(1, 0); idle(0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, '0);
    idle(1); idle(1);

    // stray write-back sets err; accept+wb on r4 keeps count at 1
    wb(7, 16'h7777); idle(1);
    wr(4, 1); idle(1);
    step(1, 0, 0, 4, 0, 0, 1, 1, 0, 1, 4, 16'h4444);
    idle(1); wb(4, 16'h4545); idle(1);

    // back-to-back independent instructions, then hold the slot
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, '0);
    idle(1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bit wen;
      int ws;
      wen = (issued.size() != 0) && ($urandom_range(1, 0) == 1);
      ws  = wen ? issued[$urandom_range(issued.size() - 1, 0)] : 0;
      step($urandom_range(3, 0) != 0,
           int'($urandom_range(NREG - 1, 0)), int'($urandom_range(NREG - 1, 0)),
           int'($urandom_range(NREG - 1, 0)),
           $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
           $urandom_range(1, 0) == 1,
           $urandom_range(3, 0) != 0, $urandom_range(9, 0) == 0,
           wen, ws, DATA_W'($urandom));
    end

    // drain everything outstanding
    for (int k = 0; k < 64 && (issued.size() != 0 || slot_full); k++) begin
      if (issued.size() != 0) begin
        rw = issued[0];
        wb(rw, DATA_W'($urandom));
      end else begin
        idle(1);
      end
    end
    idle(1); idle(1);
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_decode_pipe

// File: doc/decode_pipe.md
# decode_pipe

Pipelined decode/operand-fetch stage: the successor to the single-cycle decode stage. It holds a parametrised register file and a per-register pending-write scoreboard, and stalls on RAW hazards. Each accepted instruction is registered into a valid/ready output slot for the execute stage. It sits between fetch, which supplies the instruction plus already-decoded register selects, and execute; write-back returns through a dedicated port.

## Interface
- DATA_W, 16: register and data width
- NREG, 8: register count; REG_W = $clog2(NREG) select width
- CNT_W, 2: scoreboard counter width; max outstanding writes per register = 2^CNT_W-1
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  decode accepts this cycle
- in_instr  in  16  raw instruction, passed through
- in_pc  in  16  PC, passed through
- in_rs_sel, in_rt_sel  in  REG_W  source selects
- in_rs_use, in_rt_use  in  1  source actually read
- in_rd_sel  in  REG_W  destination select
- in_rd_wen  in  1  instruction writes rd
- out_valid  out  1  output slot occupied
- out_ready  in  1  execute consumes slot
- out_instr, out_pc  out  16  registered pass-through
- out_rs_data, out_rt_data  out  DATA_W  operands captured at accept
- out_rd_sel  out  REG_W; out_rd_wen  out  1
- flush  in  1  kill output slot (branch redirect)
- wb_en  in  1; wb_sel  in  REG_W; wb_data  in  DATA_W  write-back
- busy  out  1  any scoreboard counter nonzero
- err  out  1  sticky: write-back to a register with zero count

## Operation
- Hazard on source s (s = rs or rt), valid only if the matching in_*_use is set: cnt[s] != 0. With bypass (see Configuration), cnt[s]==1 && wb_en && wb_sel==s is not a hazard.
- Saturation stall: in_rd_wen && cnt[rd]==max.
- in_ready = !flush && !hazard && !sat && (!out_valid || out_ready).
- Accept (in_valid && in_ready): load the output slot; out_valid=1; read operands from the register file. Same-cycle wb to the same register forwards wb_data when bypass is enabled. If in_rd_wen, cnt[rd] increments.
- Consume (out_valid && out_ready && no accept): out_valid=0.
- flush: out_valid=0. If the killed slot had out_rd_wen, cnt[out_rd_sel] decrements. flush overrides consume and blocks accept.
- wb_en: regfile[wb_sel] <= wb_data. cnt[wb_sel] decrements if nonzero. If it is zero, err<=1 and the count stays 0.
- Simultaneous events on one counter: net change = +accept − wb − flush. Example: accept+wb = no change; flush+wb = −2.
- Downstream guarantees one wb per issued (unflushed) write. No in-flight kill beyond the slot.
- Register 0 is an ordinary register.

## Timing
- Reset: out_valid=0, err=0, busy=0, all counters 0, register file 0. Other outputs are 0.
- Latency: accept to out_valid is 1 cycle. A hazard resolved by wb at cycle N accepts at N with bypass, and at N+1 without.
- Output slot holds stable while out_valid && !out_ready. Throughput is 1/cycle when there are no hazards.
- in_ready is combinational from inputs and state. There is no combinational path from in_valid to in_ready.
- Reset mid-operation: all state clears immediately (async). In-flight instructions are lost.

## Configuration
- DECODE_WB_BYPASS_EN defined: same-cycle write-back forwards to operand capture and clears the hazard as described.
- Undefined: operands come from the register file only. The hazard persists until cnt==0, costing a one-cycle bubble per resolved hazard.

## Structure
- Package decode_pkg: default DATA_W/NREG/CNT_W and the derived REG_W/CNT_MAX constants.
- Sub-module decode_scoreboard: NREG counters, inc/dec ports (accept, flush, wb), hazard lookup for two sources, sat, busy, err.
- Register file and output slot live in decode_pipe.

## Test plan
- Reset, then write-back r3=0xBEEF. Accept an instruction with rs=r3 and rs_use=1. Next cycle: out_valid=1, out_rs_data=0xBEEF, and cnt stays 0.
- Accept a write to r2, then a reader of r2: in_ready=0. Then wb r2=0x1234. With bypass the reader is accepted that cycle with 0x1234; without bypass it is accepted the next cycle.
- Issue three writes to r5 with CNT_W=2. A fourth r5 writer is stalled (sat). One wb r5 makes cnt=2 and the fourth writer is accepted.
- Slot holds a writer of r1 with out_ready=0; assert flush. Then out_valid=0, cnt[r1] returns to 0, and busy=0.
- wb to r7 while cnt[r7]=0: err=1 and stays set. Accept plus wb on r4 in the same cycle (cnt=1): cnt stays 1.
- Back-to-back independent instructions with out_ready=1: one output per cycle. Toggle out_ready low: the slot stays stable and in_ready=0.
